// File: rtl/alu_result_fifo_if.sv
// Producer/consumer handshake bundle for the ALU result FIFO.
// The FIFO itself uses the slave modport; the driving environment uses master.
interface alu_result_fifo_if;
   logic        in_valid;
   logic [31:0] in_result;
   logic        in_negative;
   logic        in_zero;
   logic        in_carry;
   logic        in_overflow;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [3:0]  out_flags;

   modport master (
      output in_valid, in_result, in_negative, in_zero, in_carry, in_overflow, out_ready,
      input  in_ready, out_valid, out_result, out_flags
   );

   modport slave (
      input  in_valid, in_result, in_negative, in_zero, in_carry, in_overflow, out_ready,
      output in_ready, out_valid, out_result, out_flags
   );
endinterface

// File: rtl/alu_result_fifo.sv
// Show-ahead FIFO capturing ALU results with N/Z/C/V flags, plus sticky
// carry/overflow status and a saturating counter of results dropped while full.
module alu_result_fifo #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DROP_W = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   alu_result_fifo_if.slave         bus,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     sticky_c,
   output logic                     sticky_v,
   input  logic                     sticky_clr,
   output logic [DROP_W-1:0]        drop_count
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned EW = 36;

   logic [EW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [EW-1:0] head;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          drop;

   // Handshake status comes only from the registered count.
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign push  = bus.in_valid & ~full;
   assign pop   = bus.out_ready & ~empty;
   assign drop  = bus.in_valid & full;

   assign bus.in_ready  = ~full;
   assign bus.out_valid = ~empty;

   // Storage is not reset; stale entries are unreachable once count is zero.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {bus.in_result, bus.in_negative, bus.in_zero,
                         bus.in_carry, bus.in_overflow};
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      head = '0;
      if (!empty) head = mem[rd_ptr];
   end

   assign bus.out_result = head[35:4];
   assign bus.out_flags  = head[3:0];

   // A same-cycle set takes priority over the clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sticky_c <= 1'b0;
         sticky_v <= 1'b0;
      end else begin
         sticky_c <= (sticky_c & ~sticky_clr) | (push & bus.in_carry);
         sticky_v <= (sticky_v & ~sticky_clr) | (push & bus.in_overflow);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         drop_count <= '0;
      end else if (sticky_clr) begin
         drop_count <= DROP_W'(drop);
      end else if (drop && (drop_count != '1)) begin
         drop_count <= drop_count + DROP_W'(1);
      end
   end
endmodule
